// File: rtl/multiwave_pwm_synth.sv
// multiwave_pwm_synth: four-waveform tone synthesiser with single-pin PWM output.
// One phase accumulator drives sine/saw/triangle/square tables. The switch-selected
// sum is latched once per 1024-cycle PWM frame and compared against a free-running
// counter. Two debounced push-buttons raise or lower the phase increment.
// Optional build macro: BTN_AUTOREPEAT_EN. When it is defined, a held button repeats
// its press event every REPEAT_CYCLES.
module multiwave_pwm_synth #(
  parameter int unsigned PHASE_W         = 16,
  parameter int unsigned STEP_DEFAULT    = 64,
  parameter int unsigned STEP_INC        = 8,
  parameter int unsigned STEP_MIN        = 8,
  parameter int unsigned STEP_MAX        = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [3:0] Enable_SW,
  input  logic       Bt_Plus,
  input  logic       Bt_Minus,
  output logic       Pulse
);

  localparam int unsigned IDX_W      = 8;
  localparam int unsigned PWM_W      = 10;
  localparam int unsigned SUM_W      = PHASE_W + 1;
  localparam int unsigned DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NUM_BTN    = 2;
  localparam int unsigned BTN_PLUS   = 0;
  localparam int unsigned BTN_MINUS  = 1;
  localparam int unsigned FRAME_LAST = (1 << PWM_W) - 1;

  // Reject parameter sets the datapath cannot represent.
  if (PHASE_W < IDX_W || STEP_MIN > STEP_MAX || (STEP_MAX >> PHASE_W) != 0 ||
      STEP_DEFAULT < STEP_MIN || STEP_DEFAULT > STEP_MAX ||
      DEBOUNCE_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_cfg
    $error("multiwave_pwm_synth: inconsistent parameter set");
  end

  // Input conditioning state
  logic [3:0]                    en_meta_q, en_meta_d;
  logic [3:0]                    en_sync_q, en_sync_d;
  logic [NUM_BTN-1:0]            btn_meta_q, btn_meta_d;
  logic [NUM_BTN-1:0]            btn_sync_q, btn_sync_d;
  logic [NUM_BTN-1:0]            btn_lvl_q, btn_lvl_d;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [NUM_BTN-1:0]            press_c;
`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [NUM_BTN-1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  // Synthesis datapath state
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic               pulse_q, pulse_d;

  logic [SUM_W-1:0]   step_up_c;
  logic [IDX_W-1:0]   idx_c;
  logic [6:0]         fold_c;
  logic [7:0]         quarter_c;
  logic [7:0]         sine_c;
  logic [7:0]         saw_c;
  logic [7:0]         tri_c;
  logic [7:0]         sq_c;
  logic [PWM_W-1:0]   wave_sum_c;

  // First quadrant of round(127.5 + 127.5*sin(2*pi*i/256)), i = 0..64.
  function automatic logic [7:0] sine_quarter(input logic [6:0] a);
    logic [7:0] q;
    case (a)
      7'd0:  q = 8'd128; 7'd1:  q = 8'd131; 7'd2:  q = 8'd134; 7'd3:  q = 8'd137;
      7'd4:  q = 8'd140; 7'd5:  q = 8'd143; 7'd6:  q = 8'd146; 7'd7:  q = 8'd149;
      7'd8:  q = 8'd152; 7'd9:  q = 8'd155; 7'd10: q = 8'd158; 7'd11: q = 8'd162;
      7'd12: q = 8'd165; 7'd13: q = 8'd167; 7'd14: q = 8'd170; 7'd15: q = 8'd173;
      7'd16: q = 8'd176; 7'd17: q = 8'd179; 7'd18: q = 8'd182; 7'd19: q = 8'd185;
      7'd20: q = 8'd188; 7'd21: q = 8'd190; 7'd22: q = 8'd193; 7'd23: q = 8'd196;
      7'd24: q = 8'd198; 7'd25: q = 8'd201; 7'd26: q = 8'd203; 7'd27: q = 8'd206;
      7'd28: q = 8'd208; 7'd29: q = 8'd211; 7'd30: q = 8'd213; 7'd31: q = 8'd215;
      7'd32: q = 8'd218; 7'd33: q = 8'd220; 7'd34: q = 8'd222; 7'd35: q = 8'd224;
      7'd36: q = 8'd226; 7'd37: q = 8'd228; 7'd38: q = 8'd230; 7'd39: q = 8'd232;
      7'd40: q = 8'd234; 7'd41: q = 8'd235; 7'd42: q = 8'd237; 7'd43: q = 8'd238;
      7'd44: q = 8'd240; 7'd45: q = 8'd241; 7'd46: q = 8'd243; 7'd47: q = 8'd244;
      7'd48: q = 8'd245; 7'd49: q = 8'd246; 7'd50: q = 8'd248; 7'd51: q = 8'd249;
      7'd52: q = 8'd250; 7'd53: q = 8'd250; 7'd54: q = 8'd251; 7'd55: q = 8'd252;
      7'd56: q = 8'd253; 7'd57: q = 8'd253; 7'd58: q = 8'd254; 7'd59: q = 8'd254;
      7'd60: q = 8'd254; 7'd61: q = 8'd255; 7'd62: q = 8'd255; 7'd63: q = 8'd255;
      7'd64: q = 8'd255;
      default: q = 8'd0;
    endcase
    return q;
  endfunction

  // Synchronisers and per-button debounce; a press is the accepted 0->1 edge.
  always_comb begin
    en_meta_d  = Enable_SW;
    en_sync_d  = en_meta_q;
    btn_meta_d = {Bt_Minus, Bt_Plus};
    btn_sync_d = btn_meta_q;
    btn_lvl_d  = btn_lvl_q;
    db_cnt_d   = '0;
    press_c    = '0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d  = '0;
`endif
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_sync_q[i] != btn_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_lvl_d[i] = btn_sync_q[i];
          press_c[i]   = btn_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      // Repeat timer runs only while the accepted level is held high.
      if (btn_lvl_q[i]) begin
        if (rpt_cnt_q[i] == RPT_W'(REPEAT_CYCLES - 1)) begin
          press_c[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
        end
      end
`endif
    end
  end

  // Saturating step update; simultaneous plus and minus cancel.
  always_comb begin
    step_d    = step_q;
    step_up_c = SUM_W'(step_q) + SUM_W'(STEP_INC);
    if (press_c[BTN_PLUS] && !press_c[BTN_MINUS]) begin
      step_d = (step_up_c > SUM_W'(STEP_MAX)) ? PHASE_W'(STEP_MAX) : step_up_c[PHASE_W-1:0];
    end else if (press_c[BTN_MINUS] && !press_c[BTN_PLUS]) begin
      step_d = (SUM_W'(step_q) < SUM_W'(STEP_MIN) + SUM_W'(STEP_INC)) ?
               PHASE_W'(STEP_MIN) : step_q - PHASE_W'(STEP_INC);
    end
  end

  // Waveform lookup at the current phase index and switch-selected sum.
  always_comb begin
    idx_c     = phase_q[PHASE_W-1 -: IDX_W];
    fold_c    = idx_c[6] ? 7'(8'd128 - {1'b0, idx_c[6:0]}) : idx_c[6:0];
    quarter_c = sine_quarter(fold_c);
    if (!idx_c[7]) begin
      sine_c = quarter_c;
    end else if (idx_c[6:0] == 7'd0) begin
      // Zero crossing rounds up to 128 on both half-cycles.
      sine_c = 8'd128;
    end else begin
      sine_c = 8'd255 - quarter_c;
    end
    saw_c      = idx_c;
    tri_c      = {(idx_c[7] ? ~idx_c[6:0] : idx_c[6:0]), 1'b0};
    sq_c       = idx_c[7] ? 8'd0 : 8'd255;
    wave_sum_c = (en_sync_q[0] ? PWM_W'(sine_c) : PWM_W'(0)) +
                 (en_sync_q[1] ? PWM_W'(saw_c)  : PWM_W'(0)) +
                 (en_sync_q[2] ? PWM_W'(tri_c)  : PWM_W'(0)) +
                 (en_sync_q[3] ? PWM_W'(sq_c)   : PWM_W'(0));
  end

  // PWM frame counter; duty and phase advance only on the last cycle of a frame.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    duty_d    = duty_q;
    phase_d   = phase_q;
    if (pwm_cnt_q == PWM_W'(FRAME_LAST)) begin
      duty_d  = wave_sum_c;
      phase_d = phase_q + step_q;
    end
    pulse_d = (pwm_cnt_q < duty_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      en_meta_q  <= '0;
      en_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_lvl_q  <= '0;
      db_cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q  <= '0;
`endif
      step_q     <= PHASE_W'(STEP_DEFAULT);
      phase_q    <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      pulse_q    <= 1'b0;
    end else begin
      en_meta_q  <= en_meta_d;
      en_sync_q  <= en_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_lvl_q  <= btn_lvl_d;
      db_cnt_q   <= db_cnt_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q  <= rpt_cnt_d;
`endif
      step_q     <= step_d;
      phase_q    <= phase_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      pulse_q    <= pulse_d;
    end
  end

  assign Pulse = pulse_q;

endmodule

// File: tb/tb_multiwave_pwm_synth.sv
// Directed bench for multiwave_pwm_synth. dut_a uses the default step settings with a
// short debounce; dut_w starts at a quarter-turn step so that the waveform tables are
// visited at idx 0/64/128/192 and wrap within a few frames.
module tb_multiwave_pwm_synth;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] en_a = 4'b0000;
  logic [3:0] en_w = 4'b0000;
  logic       bt_plus = 1'b0;
  logic       bt_minus = 1'b0;
  logic       bt_off = 1'b0;
  logic       pulse_a;
  logic       pulse_w;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always #10 sysclk = ~sysclk;

  multiwave_pwm_synth #(
    .PHASE_W(16), .STEP_DEFAULT(64), .STEP_INC(8), .STEP_MIN(8), .STEP_MAX(1024),
    .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(64)
  ) dut_a (
    .sysclk(sysclk), .reset(reset), .Enable_SW(en_a),
    .Bt_Plus(bt_plus), .Bt_Minus(bt_minus), .Pulse(pulse_a)
  );

  multiwave_pwm_synth #(
    .PHASE_W(16), .STEP_DEFAULT(16384), .STEP_INC(8), .STEP_MIN(8), .STEP_MAX(16384),
    .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(64)
  ) dut_w (
    .sysclk(sysclk), .reset(reset), .Enable_SW(en_w),
    .Bt_Plus(bt_off), .Bt_Minus(bt_off), .Pulse(pulse_w)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #1;
    reset = 1'b1;
    bt_plus = 1'b0;
    bt_minus = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic align_frame();
    while ((cyc % 1024) != 0) tick();
  endtask

  task automatic count_frame(output int hi_a, output int hi_w);
    hi_a = 0;
    hi_w = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      hi_a += int'(pulse_a);
      hi_w += int'(pulse_w);
    end
  endtask

  task automatic press(input logic p, input logic m, input int hold, input int gap);
    bt_plus = p;
    bt_minus = m;
    repeat (hold) tick();
    bt_plus = 1'b0;
    bt_minus = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int ha;
    int hw;
    int exp_a[6];
    int exp_w[6];

    // No switches on dut_a; saw on dut_w walks idx 0,64,128,192 then wraps to 0.
    en_a = 4'b0000;
    en_w = 4'b0010;
    do_reset();
    check("reset_pulse", int'(pulse_a), 0);
    check("reset_step", int'(dut_a.step_q), 64);
    exp_w = '{0, 0, 64, 128, 192, 0};
    for (int f = 0; f < 6; f++) begin
      count_frame(ha, hw);
      check($sformatf("off_f%0d", f), ha, 0);
      check($sformatf("saw_w_f%0d", f), hw, exp_w[f]);
    end

    // Square alone; sine on dut_w at idx 0,64,128,192.
    en_a = 4'b1000;
    en_w = 4'b0001;
    do_reset();
    exp_a = '{0, 255, 255, 255, 255, 0};
    exp_w = '{0, 128, 255, 128, 0, 0};
    for (int f = 0; f < 5; f++) begin
      count_frame(ha, hw);
      check($sformatf("sq_f%0d", f), ha, exp_a[f]);
      check($sformatf("sine_w_f%0d", f), hw, exp_w[f]);
    end

    // All four, then sine+triangle from frame 3; triangle on dut_w.
    en_a = 4'b1111;
    en_w = 4'b0100;
    do_reset();
    exp_a = '{0, 383, 383, 128, 128, 0};
    exp_w = '{0, 0, 128, 254, 126, 0};
    for (int f = 0; f < 5; f++) begin
      if (f == 2) en_a = 4'b0101;
      count_frame(ha, hw);
      check($sformatf("mix_f%0d", f), ha, exp_a[f]);
      check($sformatf("tri_w_f%0d", f), hw, exp_w[f]);
    end

    // 24 plus presses inside frame 0 give step 256: saw duty rises by one per frame.
    en_a = 4'b0010;
    en_w = 4'b1000;
    do_reset();
    for (int n = 0; n < 24; n++) press(1'b1, 1'b0, 20, 20);
    check("step_256", int'(dut_a.step_q), 256);
    align_frame();
    exp_a = '{0, 1, 2, 3, 0, 0};
    exp_w = '{255, 255, 0, 0, 0, 0};
    for (int f = 0; f < 4; f++) begin
      count_frame(ha, hw);
      check($sformatf("saw256_f%0d", f + 1), ha, exp_a[f]);
      check($sformatf("sq_w_f%0d", f + 1), hw, exp_w[f]);
    end

    // Debounce: long hold is one event, short glitch is none, both together cancel.
    do_reset();
    check("btn_reset_step", int'(dut_a.step_q), 64);
    press(1'b1, 1'b0, 100, 40);
    check("hold_plus", int'(dut_a.step_q), 72);
    press(1'b0, 1'b1, 10, 40);
    check("glitch_minus", int'(dut_a.step_q), 72);
    press(1'b1, 1'b1, 100, 40);
    check("both_held", int'(dut_a.step_q), 72);

    // Saturation at both ends.
    do_reset();
    press(1'b0, 1'b1, 20, 20);
    check("minus_1", int'(dut_a.step_q), 56);
    for (int n = 0; n < 6; n++) press(1'b0, 1'b1, 20, 20);
    check("minus_7", int'(dut_a.step_q), 8);
    press(1'b0, 1'b1, 20, 20);
    check("minus_sat", int'(dut_a.step_q), 8);
    for (int n = 0; n < 127; n++) press(1'b1, 1'b0, 20, 20);
    check("plus_127", int'(dut_a.step_q), 1024);
    for (int n = 0; n < 3; n++) press(1'b1, 1'b0, 20, 20);
    check("plus_sat", int'(dut_a.step_q), 1024);

    // Reset from a running, saturated state.
    en_a = 4'b1000;
    do_reset();
    check("rerst_step", int'(dut_a.step_q), 64);
    count_frame(ha, hw);
    check("rerst_f0", ha, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
